// File: rtl/mux_arb_nxw.sv
// mux_arb_nxw: N-channel arbitrated multiplexer with a single registered output stage.
//
// A request is granted only when the output register can take new data: either it is
// empty, or downstream drains it on the same edge. The grant is combinational. The
// selected channel's data and index load into the output register on the granted edge.
//
// Parameters
//   N_CH : number of input channels (2..16)
//   DW   : data width per channel (1..64)
//
// Ports
//   clk       : clock; all state updates on the rising edge
//   rst_n     : asynchronous active-low reset
//   mode_in   : 00 round-robin, 01 fixed priority (lowest index wins),
//               10 forced select, 11 behaves as round-robin
//   sel_in    : channel index used in forced mode
//   req_in    : per-channel request
//   data_in   : packed channel data; channel k at [k*DW +: DW]
//   gnt_out   : one-hot accept strobe; channel k transfers on an edge where gnt_out[k]=1
//   m_out     : registered selected data
//   ch_out    : registered index of the channel that supplied m_out
//   valid_out : m_out/ch_out hold a transfer
//   ready_in  : downstream accepts when valid_out and ready_in are both high
module mux_arb_nxw #(
    parameter int unsigned N_CH = 3,
    parameter int unsigned DW   = 16,
    localparam int unsigned CW  = ($clog2(N_CH) > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           mode_in,
    input  logic [CW-1:0]        sel_in,
    input  logic [N_CH-1:0]      req_in,
    input  logic [N_CH*DW-1:0]   data_in,
    output logic [N_CH-1:0]      gnt_out,
    output logic [DW-1:0]        m_out,
    output logic [CW-1:0]        ch_out,
    output logic                 valid_out,
    input  logic                 ready_in
);

    // Request vector padded to the full index range so that any sel_in value can
    // index it; indices at or above N_CH read as "no request".
    localparam int unsigned NP = 1 << CW;

    logic [NP-1:0]   w_req_ext;
    logic            w_accept;
    logic            w_found;
    logic [CW-1:0]   w_idx;
    logic            w_grant;
    logic            w_rr_mode;
    logic [DW-1:0]   w_data;

    logic            r_valid;
    logic [DW-1:0]   r_m;
    logic [CW-1:0]   r_ch;
    logic [CW-1:0]   r_rr_ptr;

    assign w_req_ext = NP'(req_in);
    assign w_accept  = !r_valid || ready_in;
    // Reserved mode 11 shares the round-robin path.
    assign w_rr_mode = (mode_in[0] == mode_in[1]);

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        unique case (mode_in)
            2'b01: begin
                for (int i = 0; i < int'(N_CH); i++) begin
                    if (!w_found && req_in[i]) begin
                        w_found = 1'b1;
                        w_idx   = CW'(i);
                    end
                end
            end
            2'b10: begin
                if (w_req_ext[sel_in]) begin
                    w_found = 1'b1;
                    w_idx   = sel_in;
                end
            end
            default: begin
                for (int i = 0; i < int'(N_CH); i++) begin
                    int cand;
                    cand = int'(r_rr_ptr) + i;
                    if (cand >= int'(N_CH)) begin
                        cand = cand - int'(N_CH);
                    end
                    if (!w_found && w_req_ext[CW'(cand)]) begin
                        w_found = 1'b1;
                        w_idx   = CW'(cand);
                    end
                end
            end
        endcase
    end

    // Gating with rst_n keeps the strobe low for the whole reset window, not only
    // after the registers have cleared.
    assign w_grant = w_found && w_accept && rst_n;
    assign gnt_out = w_grant ? (N_CH'(1) << w_idx) : '0;
    assign w_data  = data_in[w_idx*DW +: DW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_m      <= '0;
            r_ch     <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_grant) begin
                r_valid <= 1'b1;
                r_m     <= w_data;
                r_ch    <= w_idx;
                if (w_rr_mode) begin
                    r_rr_ptr <= (w_idx == CW'(N_CH - 1)) ? '0 : w_idx + 1'b1;
                end
            end else if (ready_in) begin
                // Drained with nothing new: data and index keep their last value.
                r_valid <= 1'b0;
            end
        end
    end

    assign valid_out = r_valid;
    assign m_out     = r_m;
    assign ch_out    = r_ch;

endmodule

// File: tb/tb_mux_arb_nxw.sv
// tb_mux_arb_nxw: directed bench for mux_arb_nxw (N_CH=3, DW=16) with a reference
// arbiter model and a scoreboard of expected transfers.
module tb_mux_arb_nxw;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mode_in;
    logic [1:0]  sel_in;
    logic [2:0]  req_in;
    logic [47:0] data_in;
    logic [2:0]  gnt_out;
    logic [15:0] m_out;
    logic [1:0]  ch_out;
    logic        valid_out;
    logic        ready_in;

    mux_arb_nxw #(
        .N_CH (3),
        .DW   (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode_in   (mode_in),
        .sel_in    (sel_in),
        .req_in    (req_in),
        .data_in   (data_in),
        .gnt_out   (gnt_out),
        .m_out     (m_out),
        .ch_out    (ch_out),
        .valid_out (valid_out),
        .ready_in  (ready_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  c;
    } xfer_t;

    xfer_t       sb[$];
    int          total = 0;
    int          bad   = 0;

    // Reference state
    bit          m_valid;
    int          m_rr;
    logic [15:0] m_hold_d;
    logic [1:0]  m_hold_c;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] chan_data(input int k);
        logic [47:0] v;
        v = data_in;
        return v[k*16 +: 16];
    endfunction

    // Reference arbitration decision from the current inputs and model state.
    task automatic model_pick(output bit f, output int k);
        f = 1'b0;
        k = 0;
        if (rst_n && (!m_valid || ready_in)) begin
            if (mode_in == 2'b01) begin
                for (int i = 2; i >= 0; i--) begin
                    if (req_in[i]) begin
                        f = 1'b1;
                        k = i;
                    end
                end
            end else if (mode_in == 2'b10) begin
                if (int'(sel_in) < 3 && req_in[sel_in]) begin
                    f = 1'b1;
                    k = int'(sel_in);
                end
            end else begin
                for (int j = 0; j < 3; j++) begin
                    int c;
                    c = (m_rr + j) % 3;
                    if (!f && req_in[c]) begin
                        f = 1'b1;
                        k = c;
                    end
                end
            end
        end
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_rr     = 0;
        m_hold_d = 16'h0;
        m_hold_c = 2'd0;
        sb.delete();
    endtask

    // One clock: called just after a negedge with inputs already driven.
    task automatic cycle(input string tag);
        bit          f;
        int          k;
        logic [2:0]  eg;
        xfer_t       x;
        #1;
        model_pick(f, k);
        eg = f ? (3'b001 << k) : 3'b000;
        check({tag, ".gnt"}, 32'(gnt_out), 32'(eg));
        if (f) begin
            x.d = chan_data(k);
            x.c = 2'(k);
            sb.push_back(x);
        end
        @(posedge clk);
        if (f) begin
            m_valid = 1'b1;
            if (mode_in == 2'b00 || mode_in == 2'b11) m_rr = (k + 1) % 3;
        end else if (ready_in) begin
            m_valid = 1'b0;
        end
        #1;
        check({tag, ".valid"}, 32'(valid_out), 32'(m_valid));
        if (f) begin
            check({tag, ".sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                m_hold_d = x.d;
                m_hold_c = x.c;
            end
        end
        check({tag, ".m"}, 32'(m_out), 32'(m_hold_d));
        check({tag, ".ch"}, 32'(ch_out), 32'(m_hold_c));
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] mode, input logic [1:0] sel,
                         input logic [2:0] req, input logic rdy);
        mode_in  = mode;
        sel_in   = sel;
        req_in   = req;
        ready_in = rdy;
    endtask

    initial begin
        rst_n    = 1'b0;
        mode_in  = 2'b00;
        sel_in   = 2'd0;
        req_in   = 3'b000;
        data_in  = '0;
        ready_in = 1'b1;
        model_reset();

        // Reset with random inputs toggling
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mode_in  = 2'($urandom);
            sel_in   = 2'($urandom);
            req_in   = 3'($urandom);
            data_in  = {16'($urandom), 16'($urandom), 16'($urandom)};
            ready_in = 1'($urandom);
            #1;
            check("rst.valid", 32'(valid_out), 32'd0);
            check("rst.m", 32'(m_out), 32'h0);
            check("rst.ch", 32'(ch_out), 32'd0);
            check("rst.gnt", 32'(gnt_out), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin: expect 001,010,100,001
        data_in = {16'h3333, 16'h2222, 16'h1111};
        drive(2'b00, 2'd0, 3'b111, 1'b1);
        for (int i = 0; i < 4; i++) cycle("rr");

        // Backpressure: held three cycles, then next rr channel granted at once
        drive(2'b00, 2'd0, 3'b111, 1'b0);
        for (int i = 0; i < 3; i++) cycle("bp_hold");
        ready_in = 1'b1;
        cycle("bp_release");

        // Fixed priority with req=110, then req[1] drops
        data_in = {16'hC0C2, 16'hB0B1, 16'hA0A0};
        drive(2'b01, 2'd0, 3'b110, 1'b1);
        for (int i = 0; i < 3; i++) cycle("fix");
        req_in = 3'b100;
        cycle("fix_drop");

        // Forced select sel=2, then sel=3 (out of range) with a stalled drain
        drive(2'b10, 2'd2, 3'b111, 1'b1);
        cycle("frc2");
        cycle("frc2");
        drive(2'b10, 2'd3, 3'b111, 1'b0);
        cycle("frc3_stall");
        ready_in = 1'b1;
        cycle("frc3_drain");
        cycle("frc3_empty");

        // Reserved mode follows round-robin; leaves rr_ptr non-zero and FULL
        drive(2'b11, 2'd0, 3'b001, 1'b0);
        cycle("rsv");
        check("pre_rst.full", 32'(valid_out), 32'd1);

        // Async reset pulsed between edges
        rst_n = 1'b0;
        #1;
        check("arst.valid", 32'(valid_out), 32'd0);
        check("arst.m", 32'(m_out), 32'h0);
        check("arst.ch", 32'(ch_out), 32'd0);
        check("arst.gnt", 32'(gnt_out), 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
        drive(2'b00, 2'd0, 3'b111, 1'b1);
        cycle("post_rst");
        check("post_rst.ch0", 32'(ch_out), 32'd0);

        // Random mixed traffic
        for (int i = 0; i < 60; i++) begin
            data_in = {16'($urandom), 16'($urandom), 16'($urandom)};
            drive(2'($urandom), 2'($urandom), 3'($urandom), 1'($urandom_range(0, 3) != 0));
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mux_arb_nxw.md
MUX_ARB_NXW -- requirements
Module: mux_arb_nxw

Interface
REQ-001 SHALL have parameter N_CH, default 3, number of input channels (legal 2..16).
REQ-002 SHALL have parameter DW, default 16, data width per channel (legal 1..64).
REQ-003 SHALL define derived localparam CW = max(1, $clog2(N_CH)), the channel index width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port mode_in  input  2  arbitration mode: 00 round-robin, 01 fixed priority (lowest index wins), 10 forced select, 11 reserved and treated as 00.
REQ-007 SHALL have port sel_in  input  CW  channel index used in forced mode.
REQ-008 SHALL have port req_in  input  N_CH  per-channel request (valid).
REQ-009 SHALL have port data_in  input  N_CH*DW  packed channel data; channel k occupies bits [k*DW +: DW].
REQ-010 SHALL have port gnt_out  output  N_CH  one-hot accept strobe; channel k transfers on a clock edge where gnt_out[k]=1.
REQ-011 SHALL have port m_out  output  DW  registered selected data.
REQ-012 SHALL have port ch_out  output  CW  registered index of the channel that supplied m_out.
REQ-013 SHALL have port valid_out  output  1  m_out/ch_out hold a transfer.
REQ-014 SHALL have port ready_in  input  1  downstream accepts when valid_out and ready_in are both 1 at an edge.

Function
REQ-015 SHALL hold one output register with two states: EMPTY (valid_out=0) and FULL (valid_out=1).
REQ-016 SHALL compute accept = !valid_out || ready_in combinationally; a new grant is issued only when accept=1.
REQ-017 SHALL assert at most one gnt_out bit per cycle, and SHALL assert none when accept=0 or no eligible request exists.
REQ-018 SHALL, in round-robin mode, search channels rr_ptr, rr_ptr+1, ... wrapping modulo N_CH and grant the first one with a request.
REQ-019 SHALL, after a round-robin grant to channel k, set rr_ptr to (k+1) mod N_CH on the same edge; rr_ptr SHALL NOT change in other modes or when no grant occurs.
REQ-020 SHALL, in fixed mode, grant the lowest-index requesting channel.
REQ-021 SHALL, in forced mode, grant channel sel_in only when req_in[sel_in]=1; sel_in >= N_CH SHALL yield no grant.
REQ-022 SHALL, on a granted edge, load m_out with data of the granted channel, ch_out with its index, and set valid_out=1 (latency one cycle, throughput one transfer per cycle).
REQ-023 SHALL, on an edge with valid_out=1, ready_in=1 and no grant, clear valid_out; m_out and ch_out SHALL retain their last value.
REQ-024 SHALL keep m_out, ch_out and valid_out stable while valid_out=1 and ready_in=0.
REQ-025 SHALL apply mode_in and sel_in changes to the grant decision in the same cycle they change; no in-flight transfer is altered.
REQ-026 SHALL require each requester to hold req_in and data_in until granted; dropping req_in before grant withdraws the request without error.

Reset
REQ-027 SHALL, while rst_n=0, force valid_out=0, m_out=0, ch_out=0, rr_ptr=0, independent of clk.
REQ-028 SHALL force gnt_out=0 while rst_n=0.
REQ-029 SHALL discard any held transfer when reset asserts mid-operation; the first grant after release SHALL start from rr_ptr=0.

Verification
REQ-030 SHALL verify reset (N_CH=3, DW=16): rst_n low with random inputs -> valid_out=0, m_out=0x0000, ch_out=0, gnt_out=000.
REQ-031 SHALL verify round-robin: mode 00, req=111, data 0x1111/0x2222/0x3333, ready_in=1 -> gnt_out 001,010,100,001 on successive cycles; m_out 0x1111,0x2222,0x3333,0x1111 one cycle later.
REQ-032 SHALL verify backpressure: FULL with ready_in=0 for 3 cycles -> gnt_out=000 and m_out held; when ready_in returns to 1 -> the next round-robin channel is granted the same cycle.
REQ-033 SHALL verify fixed priority: mode 01, req=110 -> channel 1 is granted every cycle and channel 2 is not granted until req[1] drops.
REQ-034 SHALL verify forced select: mode 10, sel_in=2, req=111 -> only gnt_out=100; with sel_in=3 -> no grant, and valid_out clears after the held transfer drains.
REQ-035 SHALL verify async reset: rst_n pulsed low between edges while FULL -> outputs clear immediately without a clock edge; the first grant after release goes to channel 0 with req=111.
